// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared op encodings, FSM states and default width for the sequential divider
package alu_div_pkg;

    localparam int DIV_WIDTH = 32;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } div_state_e;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one combinational restoring-division iteration on magnitudes
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // r is always below b, so its top bit is zero and the shift cannot lose data
        r_sh  = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
        trial = r_sh - {1'b0, b};
        if (trial[WIDTH]) begin
            r_next = r_sh;
            q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            r_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/alu_seq_divider.sv
// rtl/alu_seq_divider.sv - multi-cycle radix-2 restoring DIV/DIVU/REM/REMU unit beside the ALU
module alu_seq_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] bmag_r;
    logic [1:0]       op_r;
    logic             negq_r;
    logic             negr_r;

    logic             a_neg, b_neg, b_zero, ovf, fast;
    logic [WIDTH-1:0] a_mag, b_mag, fast_res;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q, calc_quo, calc_rem, calc_res;

    // Magnitudes and sign info; -MIN_VAL wraps to itself, which is the correct unsigned magnitude
    always_comb begin
        a_neg    = ~i_op[0] & i_a[WIDTH-1];
        b_neg    = ~i_op[0] & i_b[WIDTH-1];
        a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
        b_mag    = b_neg ? (~i_b + 1'b1) : i_b;
        b_zero   = (i_b == '0);
        ovf      = ~i_op[0] & (i_a == MIN_VAL) & (i_b == '1);
        fast     = b_zero | ovf;
        if (b_zero) begin
            fast_res = i_op[1] ? i_a : '1;
        end else begin
            fast_res = i_op[1] ? '0 : MIN_VAL;
        end
    end

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (rem_r),
        .q      (quo_r),
        .b      (bmag_r),
        .r_next (step_r),
        .q_next (step_q)
    );

    always_comb begin
        calc_quo = negq_r ? (~step_q + 1'b1) : step_q;
        calc_rem = negr_r ? (~step_r[WIDTH-1:0] + 1'b1) : step_r[WIDTH-1:0];
        calc_res = op_r[1] ? calc_rem : calc_quo;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = fast ? FIN : CALC;
            CALC:    if (cnt == LAST) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state == CALC) || (state == FIN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            bmag_r     <= '0;
            op_r       <= '0;
            negq_r     <= 1'b0;
            negr_r     <= 1'b0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_div_zero <= 1'b0;
        end else begin
            o_valid <= (state == FIN);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op_r   <= i_op;
                        negq_r <= a_neg ^ b_neg;
                        negr_r <= a_neg;
                        bmag_r <= b_mag;
                        quo_r  <= a_mag;
                        rem_r  <= '0;
                        cnt    <= '0;
                        if (fast) begin
                            o_result   <= fast_res;
                            o_div_zero <= b_zero;
                        end
                    end
                end
                CALC: begin
                    rem_r <= step_r;
                    quo_r <= step_q;
                    cnt   <= cnt + 1'b1;
                    // Final iteration: fix up signs straight from the step outputs
                    if (cnt == LAST) begin
                        o_result   <= calc_res;
                        o_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// tb/tb_alu_seq_divider.sv - scoreboard bench for alu_seq_divider
module tb_alu_seq_divider;
    import alu_div_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [1:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         o_busy;
    logic         o_valid;
    logic [W-1:0] o_result;
    logic         o_div_zero;

    int checks = 0;
    int errors = 0;
    logic [W:0] sb[$];

    always #5 i_clk = ~i_clk;

    alu_seq_divider #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_div_zero (o_div_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic dz;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (!op[0]) begin
            if (a == MINV && b == '1) begin
                q = MINV;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {dz, op[1] ? r : q};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge where o_valid was seen (first IDLE cycle)
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int glitch_at, input string tag);
        logic [W:0] exp;
        int n, busy_n, exp_lat;
        bit got;
        sb.push_back(ref_div(op, a, b));
        exp_lat = (b == '0 || (!op[0] && a == MINV && b == '1)) ? 1 : W + 1;
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
        n = 0; busy_n = 0; got = 0;
        @(negedge i_clk);
        if (o_busy) busy_n++;
        while (!got && n < 100) begin
            @(posedge i_clk);
            n++;
            @(negedge i_clk);
            if (o_valid) begin
                got = 1;
            end else begin
                if (o_busy) busy_n++;
                i_start = (n == glitch_at);
                if (i_start) begin
                    i_a = $urandom; i_b = $urandom_range(1, 9); i_op = OP_DIVU;
                end
            end
        end
        i_start = 1'b0;
        check({tag, " valid"}, W'(got), 1);
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy"}, busy_n, exp_lat);
        exp = sb.pop_front();
        if (got) begin
            check({tag, " result"}, o_result, exp[W-1:0]);
            check({tag, " div_zero"}, W'(o_div_zero), W'(exp[W]));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        bit seen;
        i_rst = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge i_clk);
        check("rst busy", W'(o_busy), 0);
        check("rst valid", W'(o_valid), 0);
        check("rst result", o_result, 0);
        check("rst div_zero", W'(o_div_zero), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        do_op(OP_DIVU, 32'd100, 32'd7, 0, "divu 100/7");
        do_op(OP_REMU, 32'd100, 32'd7, 0, "remu 100/7");
        do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0, "div -100/7");
        do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 0, "rem -100/7");
        do_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 0, "rem 100/-7");
        do_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, "div 100/-7");
        do_op(OP_DIVU, 32'h1234_5678, 32'd0, 0, "divu by 0");
        do_op(OP_REMU, 32'h1234_5678, 32'd0, 0, "remu by 0");
        do_op(OP_DIV, 32'h1234_5678, 32'd0, 0, "div by 0");
        do_op(OP_REM, 32'hF234_5678, 32'd0, 0, "rem by 0");
        do_op(OP_DIV, MINV, 32'hFFFF_FFFF, 0, "div ovf");
        do_op(OP_REM, MINV, 32'hFFFF_FFFF, 0, "rem ovf");
        do_op(OP_DIVU, MINV, 32'hFFFF_FFFF, 0, "divu min/max");
        do_op(OP_DIV, MINV, 32'd3, 0, "div min/3");
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, "divu max/1");

        @(negedge i_clk);
        do_op(OP_DIVU, 32'd1000, 32'd9, 10, "ignore start calc");
        do_op(OP_DIVU, 32'd77, 32'd5, 32, "ignore start fin");
        @(negedge i_clk);
        check("fin start ignored", W'(o_busy), 0);

        do_op(OP_DIVU, 32'd100, 32'd7, 0, "pre reset");
        i_start = 1'b1; i_op = OP_DIVU; i_a = 32'd5000; i_b = 32'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (20) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("abort busy", W'(o_busy), 0);
        check("abort valid", W'(o_valid), 0);
        check("abort result", o_result, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid || o_busy) seen = 1;
        end
        check("abort no valid", W'(seen), 0);

        for (int i = 0; i < 1000; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(1, 15);
                1: rb = -$urandom_range(1, 15);
                2: rb = '0;
                3: begin ra = MINV; rb = (i % 2 == 0) ? '1 : $urandom; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(rop, ra, rb, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
